// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and small helpers
// used by the execution unit and its combinational datapath.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between a requester (master) and the ALU execution unit (slave).
interface alu_exec_unit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             busy;

  modport master (
    output in_valid, ALUControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, busy
  );

  modport slave (
    input  in_valid, ALUControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, busy
  );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; shift codes yield zero here because shifts are
// sequenced bit-serially by the execution unit.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops via alu_comb, shifts done one bit per
// cycle in SHIFT, result held in DONE until the consumer takes it.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 sll_q, sll_d;
  logic [WIDTH-1:0]     comb_y;
  logic [SHAMT_W-1:0]   shamt;
  alu_op_e              op;

  assign op    = alu_op_e'(bus.ALUControl);
  assign shamt = bus.SrcB[SHAMT_W-1:0];

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i (op),
    .a_i  (bus.SrcA),
    .b_i  (bus.SrcB),
    .y_o  (comb_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      sll_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sll_q    <= sll_d;
    end
  end

  // result_q doubles as the shift working register so no second datapath copy is needed.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sll_d    = sll_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (is_shift(op)) begin
            result_d = bus.SrcA;
            sll_d    = (op == ALU_SLL);
            cnt_d    = shamt;
            state_d  = (shamt == '0) ? S_DONE : S_SHIFT;
          end else begin
            result_d = comb_y;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        result_d = sll_q ? (result_q << 1) : (result_q >> 1);
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ALUResult = result_q;
  assign bus.Zero      = (result_q == '0);

endmodule
